fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_rd_buf.sv | 44 ++++
 rtl/fifo_rd_stream.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side streaming adapter.
package fifo_pkg;

  localparam int BUF_DEPTH_DEF = 3;
  localparam int OCC_W         = 2;

  typedef logic [OCC_W-1:0] occ_t;

  function automatic occ_t occ_update(input occ_t occ, input logic push, input logic pop);
    return occ + occ_t'(push) - occ_t'(pop);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Small ordered register queue: entry 0 is always the oldest word.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = BUF_DEPTH_DEF
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output occ_t             occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  occ_t             wr_idx;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i+1];
    shifted[DEPTH-1] = mem[DEPTH-1];
  end

  // On a simultaneous pop the queue shifts down, so the new word lands one slot lower.
  assign wr_idx = occ - occ_t'(pop);

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      occ <= occ_update(occ, push, pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && occ_t'(i) == wr_idx) mem[i] <= push_data;
        else if (pop)                    mem[i] <= shifted[i];
      end
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts an async-FIFO read port (rinc/rdata, 1-cycle latency) into a valid/ready stream.
// Optional accepted-word counter pop_cnt is built when FIFO_RD_STAT_EN is defined.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [15:0]      pop_cnt
`endif
);

  localparam logic [OCC_W:0] DEPTH_L = (OCC_W+1)'(BUF_DEPTH);

  logic             inflight;
  logic             xfer;
  occ_t             occ;
  logic [OCC_W:0]   committed;

  // Request credit counts only registered state, keeping m_ready off the rinc path.
  assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign rinc      = rrstn && !rempty && (committed < DEPTH_L);
  assign m_valid   = (occ != '0);
  assign xfer      = m_valid && m_ready;

  // Stage p1: the word requested last cycle is on rdata now.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) inflight <= 1'b0;
    else        inflight <= rinc;
  end

  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .rclk      (rclk),
    .rrstn     (rrstn),
    .push      (inflight),
    .push_data (rdata),
    .pop       (xfer),
    .occ       (occ),
    .head      (m_data)
  );

`ifdef FIFO_RD_STAT_EN
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)    pop_cnt <= '0;
    else if (xfer) pop_cnt <= pop_cnt + 16'd1;
  end
`endif

endmodule
